// File: rtl/freq_scan_pkg.sv
// rtl/freq_scan_pkg.sv - shared types and CSR constants for the frequency scan controller
//
// Contents:
//   scan_state_t      scheduler states
//   CSR_* addresses   system-side CSR word map
//   *_BIT positions   CTRL / STATUS / IRQ field bit positions

package freq_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_READ    = 3'd3,
        ST_CAPTURE = 3'd4
    } scan_state_t;

    localparam logic [3:0] CSR_CTRL        = 4'd0;
    localparam logic [3:0] CSR_STATUS      = 4'd1;
    localparam logic [3:0] CSR_IRQ         = 4'd2;
    localparam logic [3:0] CSR_RESULT_BASE = 4'd8;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int STATUS_CLR_BIT   = 0;
    localparam int STATUS_BUSY_BIT  = 31;
    localparam int IRQ_PENDING_BIT  = 0;
    localparam int IRQ_EN_BIT       = 1;

endpackage

// File: rtl/freq_scan_timer.sv
// rtl/freq_scan_timer.sv - loadable down-counter with zero flag for the settle interval
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   load        load load_value this cycle (takes priority over counting)
//   load_value  start value of the countdown
//   zero        high while the count is 0; the counter stops at 0

module freq_scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/freq_scan_ctrl.sv
// rtl/freq_scan_ctrl.sv - time-shares one frequency counter across NUM_CH sample clocks
//
// Optional feature macro: FREQ_SCAN_IRQ_EN (adds irq port and IRQ register at address 2)
//
// Ports:
//   clk            system clock (only clock)
//   reset          synchronous, active-high reset
//   csr_address    system CSR word address (0 CTRL, 1 STATUS, 2 IRQ, 8.. RESULT[ch])
//   csr_read       CSR read strobe; csr_readdata is registered, 1-cycle latency
//   csr_write      CSR write strobe
//   csr_writedata  CSR write data
//   csr_readdata   CSR read data, holds between reads
//   fc_address     freq counter CSR address, tied to 0
//   fc_read        freq counter read strobe; data returns the following cycle
//   fc_readdata    freq counter read data
//   ch_sel         external clock-mux select
//   scan_done      one-cycle pulse during the capture of the last channel
//   irq            (FREQ_SCAN_IRQ_EN only) level interrupt, PENDING & IRQ_EN

module freq_scan_ctrl
    import freq_scan_pkg::*;
#(
    parameter int NUM_CH         = 8,
    parameter int SEL_W          = 3,
    parameter int WINDOW_CYCLES  = 50000,
    parameter int SETTLE_WINDOWS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       csr_address,
    input  logic             csr_read,
    input  logic             csr_write,
    input  logic [31:0]      csr_writedata,
    output logic [31:0]      csr_readdata,
    output logic [3:0]       fc_address,
    output logic             fc_read,
    input  logic [31:0]      fc_readdata,
    output logic [SEL_W-1:0] ch_sel,
    output logic             scan_done
`ifdef FREQ_SCAN_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int SETTLE_CYCLES = SETTLE_WINDOWS * WINDOW_CYCLES;
    localparam int TMR_W         = $clog2(SETTLE_CYCLES);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_CH - 1);

    scan_state_t       state, state_next;
    logic [SEL_W-1:0]  ch;
    logic              ctrl_en, ctrl_oneshot;
    logic [NUM_CH-1:0] valid;
    logic [31:0]       results [NUM_CH];
    logic [31:0]       rd_mux;

    logic sel_strobe, timer_load, timer_zero, capture;
    logic last_ch, busy;
    logic ctrl_wr, status_clr;
    logic unused_wdata;

    assign fc_address   = 4'd0;
    assign last_ch      = (ch == LAST_CH);
    assign busy         = (state != ST_IDLE);
    assign ctrl_wr      = csr_write && (csr_address == CSR_CTRL);
    assign status_clr   = csr_write && (csr_address == CSR_STATUS) && csr_writedata[STATUS_CLR_BIT];
    assign unused_wdata = ^csr_writedata[31:2];

    freq_scan_timer #(
        .W(TMR_W)
    ) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (SETTLE_LOAD),
        .zero       (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sel_strobe = 1'b0;
        timer_load = 1'b0;
        fc_read    = 1'b0;
        capture    = 1'b0;
        scan_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_en) state_next = ST_SELECT;
            end
            ST_SELECT: begin
                sel_strobe = 1'b1;
                timer_load = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer_zero) state_next = ST_READ;
            end
            ST_READ: begin
                fc_read    = 1'b1;
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                if (last_ch) begin
                    scan_done  = 1'b1;
                    state_next = ctrl_oneshot ? ST_IDLE : ST_SELECT;
                end else begin
                    state_next = ST_SELECT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Software dropped EN: abandon the channel in flight without touching
        // the mux, the counter or the stored results.
        if (busy && !ctrl_en) begin
            state_next = ST_IDLE;
            sel_strobe = 1'b0;
            timer_load = 1'b0;
            fc_read    = 1'b0;
            capture    = 1'b0;
            scan_done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch           <= '0;
            ch_sel       <= '0;
            ctrl_en      <= 1'b0;
            ctrl_oneshot <= 1'b0;
            valid        <= '0;
            csr_readdata <= '0;
            for (int i = 0; i < NUM_CH; i++) results[i] <= '0;
        end else begin
            if (sel_strobe) ch_sel <= ch;

            if (capture) begin
                ch <= last_ch ? '0 : ch + SEL_W'(1);
            end else if (state == ST_IDLE) begin
                ch <= '0;
            end

            // A software CTRL write overrides the end-of-oneshot clear. The
            // whole register is cleared so CTRL reads back 0 after a oneshot.
            if (ctrl_wr) begin
                ctrl_en      <= csr_writedata[CTRL_EN_BIT];
                ctrl_oneshot <= csr_writedata[CTRL_ONESHOT_BIT];
            end else if (capture && last_ch && ctrl_oneshot) begin
                ctrl_en      <= 1'b0;
                ctrl_oneshot <= 1'b0;
            end

            // The capture set comes after the clear so a coinciding clear
            // still leaves the freshly captured channel marked valid.
            if (status_clr) valid <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture && (ch == SEL_W'(i))) begin
                    valid[i]   <= 1'b1;
                    results[i] <= fc_readdata;
                end
            end

            if (csr_read) csr_readdata <= rd_mux;
        end
    end

`ifdef FREQ_SCAN_IRQ_EN
    logic irq_pending, irq_en;
    logic irq_wr;

    assign irq_wr = csr_write && (csr_address == CSR_IRQ);
    assign irq    = irq_pending && irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pending <= 1'b0;
            irq_en      <= 1'b0;
        end else begin
            if (scan_done) begin
                irq_pending <= 1'b1;
            end else if (irq_wr && csr_writedata[IRQ_PENDING_BIT]) begin
                irq_pending <= 1'b0;
            end
            if (irq_wr) irq_en <= csr_writedata[IRQ_EN_BIT];
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            CSR_CTRL: begin
                rd_mux[CTRL_EN_BIT]      = ctrl_en;
                rd_mux[CTRL_ONESHOT_BIT] = ctrl_oneshot;
            end
            CSR_STATUS: begin
                rd_mux[NUM_CH-1:0]      = valid;
                rd_mux[STATUS_BUSY_BIT] = busy;
            end
`ifdef FREQ_SCAN_IRQ_EN
            CSR_IRQ: begin
                rd_mux[IRQ_PENDING_BIT] = irq_pending;
                rd_mux[IRQ_EN_BIT]      = irq_en;
            end
`endif
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (csr_address == (CSR_RESULT_BASE + 4'(i))) rd_mux = results[i];
        end
    end

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// tb/tb_freq_scan_ctrl.sv - scoreboard bench for freq_scan_ctrl

module tb_freq_scan_ctrl;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       csr_address = '0;
    logic             csr_read = 1'b0;
    logic             csr_write = 1'b0;
    logic [31:0]      csr_writedata = '0;
    logic [31:0]      csr_readdata;
    logic [3:0]       fc_address;
    logic             fc_read;
    logic [31:0]      fc_readdata = '0;
    logic [SEL_W-1:0] ch_sel;
    logic             scan_done;
`ifdef FREQ_SCAN_IRQ_EN
    logic             irq;
`endif

    freq_scan_ctrl #(
        .NUM_CH(NUM_CH), .SEL_W(SEL_W), .WINDOW_CYCLES(10), .SETTLE_WINDOWS(2)
    ) dut (
        .clk(clk), .reset(reset),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
        .fc_address(fc_address), .fc_read(fc_read), .fc_readdata(fc_readdata),
        .ch_sel(ch_sel), .scan_done(scan_done)
`ifdef FREQ_SCAN_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Frequency counter model: returns fc_base + selected channel one cycle after fc_read.
    int fc_base = 1000;
    always @(posedge clk) if (fc_read === 1'b1) fc_readdata <= 32'(fc_base) + 32'(ch_sel);

    logic rd_q = 1'b0;
    always @(posedge clk) rd_q <= csr_read;

    logic [31:0]      rd_exp_q [$];
    logic [3:0]       rd_addr_q [$];
    logic [SEL_W-1:0] sel_exp_q [$];
    logic [31:0]      mon_e;
    logic [3:0]       mon_a;
    int n_pass = 0;
    int n_total = 0;
    int k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rd_q) begin
            if (rd_exp_q.size() == 0) begin
                n_total++;
                $display("FAIL csr_rd_unexpected: got 0x%08h expected no read data", csr_readdata);
            end else begin
                mon_e = rd_exp_q.pop_front();
                mon_a = rd_addr_q.pop_front();
                check($sformatf("csr_rd[%0d]", mon_a), csr_readdata, mon_e);
            end
        end
        if (!reset && fc_read === 1'b1) begin
            check("fc_address", 32'(fc_address), 32'd0);
            if (sel_exp_q.size() == 0) begin
                n_total++;
                $display("FAIL fc_read_unexpected: got ch_sel %0d expected no fc_read", ch_sel);
            end else begin
                check("fc_read_ch_sel", 32'(ch_sel), 32'(sel_exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] a, input logic [31:0] e);
        rd_addr_q.push_back(a);
        rd_exp_q.push_back(e);
        csr_address = a; csr_read = 1'b1;
        @(posedge clk); #1;
        csr_read = 1'b0;
    endtask

    task automatic push_sel(input int n);
        for (int i = 0; i < n; i++) sel_exp_q.push_back(SEL_W'(i));
    endtask

    // Cycles from the enabling write edge to the first scan_done; -1 if none within 200.
    task automatic wait_done(output int cyc);
        int i;
        cyc = -1;
        i = 0;
        while (cyc < 0 && i < 200) begin
            i++;
            @(posedge clk); #1;
            if (scan_done === 1'b1) cyc = i;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_ch_sel", 32'(ch_sel), 32'd0);
        check("rst_fc_read", 32'(fc_read), 32'd0);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        check("rst_readdata", csr_readdata, 32'd0);
        reset = 1'b0;
        csr_rd(4'd0, 32'h0);
        csr_rd(4'd1, 32'h0);

        // 1: continuous scan
        push_sel(4);
        csr_wr(4'd0, 32'd1);
        wait_done(k);
        check("t1_scan_done_cycle", 32'(k), 32'd92);
        tick(1);
        check("t1_scan_done_pulse", 32'(scan_done), 32'd0);
        tick(4);
        csr_rd(4'd1, 32'h8000000F);
        for (int i = 0; i < 4; i++) csr_rd(4'(8 + i), 32'(1000 + i));
        csr_wr(4'd0, 32'd0);
        tick(3);
        csr_rd(4'd0, 32'h0);
        csr_rd(4'd1, 32'h0000000F);
        check("t1_fc_read_count", 32'(sel_exp_q.size()), 32'd0);

        // 2: oneshot
        csr_wr(4'd1, 32'd1);
        csr_rd(4'd1, 32'h0);
        push_sel(4);
        csr_wr(4'd0, 32'd3);
        wait_done(k);
        check("t2_scan_done_cycle", 32'(k), 32'd92);
        tick(30);
        csr_rd(4'd0, 32'h0);
        csr_rd(4'd1, 32'h0000000F);
        csr_rd(4'd9, 32'd1001);
        check("t2_fc_read_count", 32'(sel_exp_q.size()), 32'd0);

        // 3: abort during ch 2 settle, then restart from ch 0
        csr_wr(4'd1, 32'd1);
        fc_base = 2000;
        push_sel(2);
        csr_wr(4'd0, 32'd1);
        tick(54);
        csr_wr(4'd0, 32'd0);
        tick(1);
        check("t3_ch_sel_hold", 32'(ch_sel), 32'd2);
        check("t3_fc_read_off", 32'(fc_read), 32'd0);
        csr_rd(4'd1, 32'h00000003);
        tick(30);
        csr_rd(4'd10, 32'd1002);
        csr_rd(4'd8, 32'd2000);
        csr_rd(4'd9, 32'd2001);
        push_sel(1);
        csr_wr(4'd0, 32'd1);
        tick(2);
        check("t3_restart_ch_sel", 32'(ch_sel), 32'd0);
        tick(25);
        csr_wr(4'd0, 32'd0);
        tick(3);
        check("t3_fc_read_count", 32'(sel_exp_q.size()), 32'd0);

        // 4: STATUS clear coinciding with capture of ch 1; zero result kept
        fc_base = 0;
        push_sel(2);
        csr_wr(4'd0, 32'd1);
        tick(46);
        csr_wr(4'd1, 32'd1);
        csr_rd(4'd1, 32'h80000002);
        csr_wr(4'd0, 32'd0);
        tick(3);
        csr_rd(4'd8, 32'd0);
        csr_rd(4'd9, 32'd1);
        csr_rd(4'd1, 32'h00000002);

        // 5: unmapped addresses, then reset mid-settle
        fc_base = 500;
        csr_rd(4'd5, 32'h0);
        csr_rd(4'd3, 32'h0);
        csr_rd(4'd12, 32'h0);
        csr_wr(4'd5, 32'hFFFFFFFF);
        csr_rd(4'd0, 32'h0);
`ifndef FREQ_SCAN_IRQ_EN
        csr_rd(4'd2, 32'h0);
`endif
        push_sel(1);
        csr_wr(4'd0, 32'd1);
        tick(30);
        csr_rd(4'd9, 32'd1);
        reset = 1'b1;
        tick(1);
        check("t5_rst_ch_sel", 32'(ch_sel), 32'd0);
        check("t5_rst_readdata", csr_readdata, 32'd0);
        check("t5_rst_fc_read", 32'(fc_read), 32'd0);
        check("t5_rst_scan_done", 32'(scan_done), 32'd0);
        tick(1);
        reset = 1'b0;
        csr_rd(4'd1, 32'h0);
        csr_rd(4'd0, 32'h0);
        csr_rd(4'd8, 32'h0);

`ifdef FREQ_SCAN_IRQ_EN
        // 6: interrupt
        fc_base = 1000;
        csr_wr(4'd2, 32'd2);
        csr_rd(4'd2, 32'd2);
        push_sel(4);
        csr_wr(4'd0, 32'd3);
        wait_done(k);
        check("t6_scan_done_cycle", 32'(k), 32'd92);
        check("t6_irq_before", 32'(irq), 32'd0);
        tick(1);
        check("t6_irq_set", 32'(irq), 32'd1);
        csr_rd(4'd2, 32'd3);
        csr_wr(4'd2, 32'd3);
        check("t6_irq_clear", 32'(irq), 32'd0);
        csr_rd(4'd2, 32'd2);
`endif

        tick(2);
        check("fc_read_leftover", 32'(sel_exp_q.size()), 32'd0);
        check("csr_rd_leftover", 32'(rd_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
